pwm_regs_multi: RTL
===================

// Module: pwm_regs_multi
// PURPOSE
//  Byte-wide register bank for an NCH-channel PWM generator with counter width CW (8/16/24/32).
//  Sits between the host bus decoder and the per-channel counter/compare units.
//  New relative to the single-channel bank: channel addressing, registered read-valid, sticky per-channel status,
//  access-error flag, parametrised count_reset pulse, optional double-buffered period/compare.
// PARAMETERS
//  NCH        4   number of channels, 1..8
//  CW         16  counter/compare width in bits, multiple of 8, 8..32
//  AW         8   address width; addr[AW-1:5]=channel, addr[4:0]=offset; NCH <= 2**(AW-5)
//  RST_PULSE  2   count_reset pulse length in cycles, 1..15
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  rst          in   1        asynchronous, active-high reset
//  read         in   1        read strobe, one access per cycle
//  write        in   1        write strobe
//  addr         in   AW       {channel, offset}
//  data_write   in   8        write data
//  data_read    out  8        read data, registered
//  rd_valid     out  1        one-cycle pulse: data_read valid
//  addr_err     out  1        one-cycle pulse: access to channel >= NCH or undefined offset
//  counter_val  in   NCH*CW   live counters, channel c at [c*CW +: CW]
//  update_evt   in   NCH      per-channel period-boundary pulse from counter
//  period       out  NCH*CW   active period per channel
//  compare1     out  NCH*CW   active compare1 per channel
//  compare2     out  NCH*CW   active compare2 per channel
//  prescale     out  NCH*8    prescaler per channel
//  functions    out  NCH*8    mode bits per channel
//  en, upnotdown, pwm_en, count_reset  out  NCH each  per-channel control bits
// BEHAVIOUR
//  Offsets: 00-03 period byte0-3; 04-07 compare1; 08-0B compare2; 0C-0F counter_val (RO);
//   10 ctrl {4'b0, count_reset, pwm_en, upnotdown, en}; 11 prescale; 12 functions;
//   13 status {7'b0, ovf} (bit0 write-1-to-clear); 14-1F undefined.
//  Bytes at or above CW/8 in a multi-byte field: read 0, write ignored, no addr_err.
//  Reset: every output and register 0; rd_valid=0, addr_err=0, data_read=0; pulse counters idle.
//  Read: data_read and rd_valid update on the edge after read=1 (latency 1); data_read holds otherwise.
//  Bad channel or undefined offset: read returns 0 with rd_valid=1; write has no effect; addr_err pulses 1 cycle.
//  read and write in the same cycle to the same byte: read returns the pre-write value; write still applies.
//  Writing ctrl bit3=1: count_reset[c]=1 for exactly RST_PULSE cycles, then self-clears; rewrite during the
//   pulse restarts the count. Bit3=0 does not truncate a running pulse. Reading bit3 returns the live output.
//  ovf[c] is set on update_evt[c]; cleared by writing status bit0=1; set wins on a same-cycle set and clear.
//  rst asserted mid-pulse or mid-read: immediate return to reset values; no rd_valid for the interrupted read.
// CONFIGURATION
//  PWM_REGS_SHADOW_EN defined: period/compare1/compare2 writes go to shadow registers. Active output is
//   loaded from shadow on the edge after update_evt[c]=1, or on every cycle while en[c]=0. Readback returns
//   shadow. A write in the same cycle as update_evt: the new byte is not loaded; it waits for the next event.
//  Undefined: writes update the active outputs directly on the next edge; readback returns active.
// TESTING
//  Reset, then read every offset of ch0 -> all 0, rd_valid one cycle after each read.
//  Write ch2 period 0x34 then 0x12 (CW=16) -> period[2*16+:16]=0x1234; read off 02 -> 0, no addr_err.
//  Write ctrl=0x08 to ch1, RST_PULSE=2 -> count_reset[1] high exactly 2 cycles; rewrite at cycle 1 -> 3 cycles.
//  update_evt[3] pulse -> status ch3 reads 1; write 0x01 with update_evt[3] same cycle -> stays 1.
//  Access channel NCH (4) -> addr_err pulse, read 0, no register change.
//  SHADOW_EN, en[0]=1: write compare1=0x80 -> output unchanged until update_evt[0], loaded next edge.

Source files
------------

// File: rtl/pwm_regs_multi_if.sv
// Host-side register bus for pwm_regs_multi: one byte access per cycle,
// registered read data with a read-valid pulse and an access-error pulse.
interface pwm_regs_multi_if #(
  parameter int AW = 8
);
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [7:0]    data_write;
  logic [7:0]    data_read;
  logic          rd_valid;
  logic          addr_err;

  modport master (
    output read, write, addr, data_write,
    input  data_read, rd_valid, addr_err
  );

  modport slave (
    input  read, write, addr, data_write,
    output data_read, rd_valid, addr_err
  );
endinterface

// File: rtl/pwm_regs_multi.sv
// NCH-channel byte-wide PWM register bank with sticky overflow status and a
// self-clearing count_reset pulse. Define PWM_REGS_SHADOW_EN for double-buffered period/compare.

module pwm_regs_ch #(
  parameter int CW        = 16,
  parameter int RST_PULSE = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [4:0]    off,
  input  logic [7:0]    wdata,
  input  logic [CW-1:0] cnt,
  input  logic          evt,
  output logic [CW-1:0] period,
  output logic [CW-1:0] compare1,
  output logic [CW-1:0] compare2,
  output logic [7:0]    prescale,
  output logic [7:0]    functions,
  output logic          en,
  output logic          upnotdown,
  output logic          pwm_en,
  output logic          count_reset,
  output logic [7:0]    rd_byte
);
  localparam int NB = CW / 8;

  // Write-visible copies; these are the active values unless shadowing is enabled.
  logic [CW-1:0] per_w, cmp1_w, cmp2_w;
  logic [3:0]    pulse_cnt;
  logic          ovf;

  function automatic logic [7:0] fbyte(input logic [CW-1:0] v, input logic [1:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      if (b == 2'(i)) r = v[i*8 +: 8];
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_w     <= '0;
      cmp1_w    <= '0;
      cmp2_w    <= '0;
      prescale  <= '0;
      functions <= '0;
      en        <= 1'b0;
      upnotdown <= 1'b0;
      pwm_en    <= 1'b0;
      pulse_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      if (wr) begin
        for (int i = 0; i < NB; i++) begin
          if (off == 5'(i))     per_w[i*8 +: 8]  <= wdata;
          if (off == 5'(4 + i)) cmp1_w[i*8 +: 8] <= wdata;
          if (off == 5'(8 + i)) cmp2_w[i*8 +: 8] <= wdata;
        end
        case (off)
          5'h10:   {pwm_en, upnotdown, en} <= wdata[2:0];
          5'h11:   prescale  <= wdata;
          5'h12:   functions <= wdata;
          default: ;
        endcase
      end
      // A bit3 write reloads the pulse; a bit3=0 write lets it run out.
      if (wr && off == 5'h10 && wdata[3])
        pulse_cnt <= 4'(RST_PULSE);
      else if (pulse_cnt != 4'd0)
        pulse_cnt <= pulse_cnt - 4'd1;
      if (evt)
        ovf <= 1'b1;
      else if (wr && off == 5'h13 && wdata[0])
        ovf <= 1'b0;
    end
  end

  assign count_reset = (pulse_cnt != 4'd0);

`ifdef PWM_REGS_SHADOW_EN
  // Active copy follows the shadow at period boundaries, or continuously while stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period   <= '0;
      compare1 <= '0;
      compare2 <= '0;
    end else if (evt || !en) begin
      period   <= per_w;
      compare1 <= cmp1_w;
      compare2 <= cmp2_w;
    end
  end
`else
  assign period   = per_w;
  assign compare1 = cmp1_w;
  assign compare2 = cmp2_w;
`endif

  always_comb begin
    rd_byte = '0;
    case (off)
      5'h00, 5'h01, 5'h02, 5'h03: rd_byte = fbyte(per_w, off[1:0]);
      5'h04, 5'h05, 5'h06, 5'h07: rd_byte = fbyte(cmp1_w, off[1:0]);
      5'h08, 5'h09, 5'h0A, 5'h0B: rd_byte = fbyte(cmp2_w, off[1:0]);
      5'h0C, 5'h0D, 5'h0E, 5'h0F: rd_byte = fbyte(cnt, off[1:0]);
      5'h10:   rd_byte = {4'b0, count_reset, pwm_en, upnotdown, en};
      5'h11:   rd_byte = prescale;
      5'h12:   rd_byte = functions;
      5'h13:   rd_byte = {7'b0, ovf};
      default: rd_byte = '0;
    endcase
  end
endmodule

module pwm_regs_multi #(
  parameter int NCH       = 4,
  parameter int CW        = 16,
  parameter int AW        = 8,
  parameter int RST_PULSE = 2
) (
  input  logic                clk,
  input  logic                rst,
  pwm_regs_multi_if.slave     bus,
  input  logic [NCH*CW-1:0]   counter_val,
  input  logic [NCH-1:0]      update_evt,
  output logic [NCH*CW-1:0]   period,
  output logic [NCH*CW-1:0]   compare1,
  output logic [NCH*CW-1:0]   compare2,
  output logic [NCH*8-1:0]    prescale,
  output logic [NCH*8-1:0]    functions,
  output logic [NCH-1:0]      en,
  output logic [NCH-1:0]      upnotdown,
  output logic [NCH-1:0]      pwm_en,
  output logic [NCH-1:0]      count_reset
);
  localparam int CHW = AW - 5;

  logic [CHW-1:0]       chan;
  logic [4:0]           off;
  logic                 acc_ok;
  logic [NCH-1:0][7:0]  rd_bytes;
  logic [7:0]           rd_mux;

  assign chan   = bus.addr[AW-1:5];
  assign off    = bus.addr[4:0];
  assign acc_ok = ({1'b0, chan} < (CHW+1)'(NCH)) && (off < 5'h14);

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NCH; c++)
      if (chan == CHW'(c)) rd_mux = rd_bytes[c];
    if (!acc_ok) rd_mux = '0;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pwm_regs_ch #(.CW(CW), .RST_PULSE(RST_PULSE)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr          (bus.write && acc_ok && (chan == CHW'(c))),
      .off         (off),
      .wdata       (bus.data_write),
      .cnt         (counter_val[c*CW +: CW]),
      .evt         (update_evt[c]),
      .period      (period[c*CW +: CW]),
      .compare1    (compare1[c*CW +: CW]),
      .compare2    (compare2[c*CW +: CW]),
      .prescale    (prescale[c*8 +: 8]),
      .functions   (functions[c*8 +: 8]),
      .en          (en[c]),
      .upnotdown   (upnotdown[c]),
      .pwm_en      (pwm_en[c]),
      .count_reset (count_reset[c]),
      .rd_byte     (rd_bytes[c])
    );
  end

  // Read data is sampled before any same-cycle write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_read <= '0;
      bus.rd_valid  <= 1'b0;
      bus.addr_err  <= 1'b0;
    end else begin
      bus.rd_valid <= bus.read;
      bus.addr_err <= (bus.read || bus.write) && !acc_ok;
      if (bus.read) bus.data_read <= rd_mux;
    end
  end
endmodule
